// File: rtl/disp_pkg.sv
// Shared display-path types and constants for the binary-to-BCD converter.
package disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } b2b_state_t;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import disp_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // Add-3 correction, plain 4-bit add with an unsigned compare.
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking mask is built when BIN2BCD_BLANK_EN is defined;
// otherwise the blank port is tied to zero.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int IN_W   = 26,
    parameter int DIGITS = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int CNT_W   = $clog2(IN_W + 1);

    b2b_state_t         state;
    b2b_state_t         state_nxt;
    logic [IN_W-1:0]    bin_sr;
    logic [BCD_TOT-1:0] bcd_sr;
    logic [BCD_TOT-1:0] bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;
    logic [BCD_TOT-1:0] result;

    // One correction cell per scratch digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_sr [g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: load on start, shift IN_W times, one cycle to publish.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ready = (state == S_IDLE);

    // Overflowed conversions saturate to all nines.
    always_comb begin
        result = ovf_acc ? {DIGITS{BCD_NINE}} : bcd_sr;
    end

    // Datapath: operand load, shift-add-3 iterations, result publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            valid   <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        bcd_sr  <= '0;
                        cnt     <= CNT_W'(IN_W);
                        ovf_acc <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // A bit falling off the top digit means the value needs more digits.
                    bcd_sr  <= {bcd_adj[BCD_TOT-2:0], bin_sr[IN_W-1]};
                    bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
                    ovf_acc <= ovf_acc | bcd_adj[BCD_TOT-1];
                    cnt     <= cnt - CNT_W'(1);
                end
                S_DONE: begin
                    bcd_out <= result;
                    ovf     <= ovf_acc;
                    valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              lead;

    // Blank every digit above the most significant nonzero one; digit 0 always shown.
    always_comb begin
        blank_nxt = '0;
        lead      = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead         = lead & (bcd_sr[i*BCD_W +: BCD_W] == 4'd0);
            blank_nxt[i] = lead;
        end
        if (ovf_acc) blank_nxt = '0;
    end

    // Blank mask is published alongside bcd_out.
    always_ff @(posedge clk) begin
        if (rst)                  blank <= '0;
        else if (state == S_DONE) blank <= blank_nxt;
    end
`else
    assign blank = '0;
`endif

endmodule
